// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared types and helpers for the global pooling layer.
//   pool_mode_e  : run-time pooling mode (AVG, MAX, ABSAVG; code 3 acts as AVG)
//   pool_state_e : top-level frame state (ACCUM, FINISH)
//   decode_mode  : maps the raw 2-bit mode input onto pool_mode_e
//   sat_signed   : clamps a wide signed value into a signed range of 'bits' bits
// ---------------------------------------------------------------------------
package pool_pkg;

    typedef enum logic [1:0] {
        POOL_AVG    = 2'd0,
        POOL_MAX    = 2'd1,
        POOL_ABSAVG = 2'd2
    } pool_mode_e;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_FINISH = 1'b1
    } pool_state_e;

    // The unused code 3 is folded onto AVG so the latched mode is always legal.
    function automatic pool_mode_e decode_mode(input logic [1:0] raw);
        pool_mode_e mode;
        case (raw)
            2'd1:    mode = POOL_MAX;
            2'd2:    mode = POOL_ABSAVG;
            default: mode = POOL_AVG;
        endcase
        return mode;
    endfunction

    // Clamp to [-2^(bits-1), 2^(bits-1)-1]; caller keeps the low 'bits' bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned       bits);
        logic signed [63:0] maxVal;
        logic signed [63:0] minVal;
        maxVal = (64'sd1 <<< (bits - 1)) - 64'sd1;
        minVal = -(64'sd1 <<< (bits - 1));
        if (value > maxVal) begin
            return maxVal;
        end else if (value < minVal) begin
            return minVal;
        end
        return value;
    endfunction

endpackage

// File: rtl/pool_channel.sv
// ---------------------------------------------------------------------------
// pool_channel
// One pooling lane: accumulates a frame of signed samples according to the
// pooling mode and presents the pooled word combinationally.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_clear          : clears the accumulator (frame restart or result taken)
//   i_accept         : a sample handshake happens this cycle
//   i_first          : the accepted sample is the first one of its frame
//   i_accMode        : mode used to fold the incoming sample
//   i_resMode        : latched frame mode used to form the result
//   i_data           : signed input sample
//   o_result         : pooled word (AVG/ABSAVG scaled and saturated, MAX raw)
// ---------------------------------------------------------------------------
module pool_channel
    import pool_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int INPUT_SIZE = 113,
    parameter int RECIP_BITS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_accept,
    input  logic                 i_first,
    input  pool_mode_e           i_accMode,
    input  pool_mode_e           i_resMode,
    input  logic [WORD_SIZE-1:0] i_data,
    output logic [WORD_SIZE-1:0] o_result
);

    localparam int AW = WORD_SIZE + $clog2(INPUT_SIZE);
    localparam int PW = AW + RECIP_BITS + 2;

    localparam longint RECIP = ((longint'(1) <<< RECIP_BITS) + longint'(INPUT_SIZE / 2))
                               / longint'(INPUT_SIZE);

    localparam logic signed [PW-1:0]        RECIP_W  = PW'(RECIP);
    localparam logic signed [PW-1:0]        ROUND_W  = PW'(longint'(1) <<< (RECIP_BITS - 1));
    localparam logic signed [AW-1:0]        ACC_MIN  = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [WORD_SIZE-1:0] WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
    localparam logic signed [WORD_SIZE-1:0] WORD_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};

    logic signed [AW-1:0]        r_acc;
    logic signed [WORD_SIZE-1:0] w_x;
    logic signed [AW-1:0]        w_sample;
    logic signed [AW-1:0]        w_abs;
    logic signed [AW-1:0]        w_base;
    logic signed [AW-1:0]        w_next;
    logic signed [PW-1:0]        w_accWide;
    logic signed [PW-1:0]        w_scaled;
    logic        [WORD_SIZE-1:0] w_avgWord;

    assign w_x      = signed'(i_data);
    assign w_sample = AW'(w_x);

    // |most-negative| has no positive twin, so it saturates to the largest word.
    assign w_abs = (w_x == WORD_MIN) ? AW'(WORD_MAX)
                 : (w_x < 0)         ? -w_sample
                 :                     w_sample;

    // The first sample of a frame folds against the mode's identity value
    // (0 for sums, most-negative for MAX) instead of the stored accumulator,
    // so the mode chosen at that sample is honoured even though the clear
    // happened before the mode was known.
    always_comb begin
        w_base = r_acc;
        w_next = r_acc;
        if (i_first) begin
            w_base = (i_accMode == POOL_MAX) ? ACC_MIN : '0;
        end
        case (i_accMode)
            POOL_MAX:    w_next = (w_sample > w_base) ? w_sample : w_base;
            POOL_ABSAVG: w_next = w_base + w_abs;
            default:     w_next = w_base + w_sample;
        endcase
    end

    // Accumulator register; a clear overrides any sample in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_accept) begin
            r_acc <= w_next;
        end
    end

    // Division by the frame length is a multiply by a rounded reciprocal with
    // round-half-up before the arithmetic shift.
    assign w_accWide = PW'(r_acc);
    assign w_scaled  = (w_accWide * RECIP_W + ROUND_W) >>> RECIP_BITS;
    assign w_avgWord = WORD_SIZE'(sat_signed(64'(w_scaled), WORD_SIZE));

    assign o_result = (i_resMode == POOL_MAX) ? r_acc[WORD_SIZE-1:0] : w_avgWord;

endmodule

// File: rtl/global_pool_layer.sv
// ---------------------------------------------------------------------------
// global_pool_layer
// Reduces INPUT_SIZE samples on each of CHANNELS lanes to one pooled word per
// lane (average, max, or average of absolute values).
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   start_i          : synchronous frame abort/restart
//   mode_i           : pooling mode, latched at the first sample of a frame
//   valid_i/ready_o  : input vector handshake (ready_o low only in FINISH)
//   data_i           : CHANNELS signed words, lane 0 in the low bits
//   valid_o/ready_i  : output vector handshake
//   data_o           : CHANNELS pooled signed words, lane 0 in the low bits
// ---------------------------------------------------------------------------
module global_pool_layer
    import pool_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int INT_BITS   = 4,
    parameter int CHANNELS   = 256,
    parameter int INPUT_SIZE = 113,
    parameter int RECIP_BITS = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [1:0]                    mode_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [CHANNELS*WORD_SIZE-1:0] data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [CHANNELS*WORD_SIZE-1:0] data_o
);

    // Fractional bit count of the fixed-point format; the pooling arithmetic is
    // format-agnostic, so this only documents how data words are interpreted.
    localparam int N_SIZE = WORD_SIZE - INT_BITS;

    localparam int            CW   = $clog2(INPUT_SIZE);
    localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

    pool_state_e                   r_state;
    logic [CW-1:0]                 r_count;
    pool_mode_e                    r_mode;
    logic                          w_accept;
    logic                          w_first;
    logic                          w_load;
    logic                          w_clear;
    pool_mode_e                    w_accMode;
    logic [CHANNELS*WORD_SIZE-1:0] w_results;

    assign ready_o = (r_state == ST_ACCUM);

    // An abort wins over a simultaneous sample, which is simply dropped.
    assign w_accept = valid_i & ready_o & ~start_i;
    assign w_first  = (r_count == '0);

    // The first sample must fold with the incoming mode, not the stale latch.
    assign w_accMode = w_first ? decode_mode(mode_i) : r_mode;

    // The result moves to the output register whenever it is empty or being
    // drained this cycle; an abort in FINISH discards the result instead.
    assign w_load  = (r_state == ST_FINISH) & (~valid_o | ready_i) & ~start_i;
    assign w_clear = start_i | w_load;

    // Frame state machine, sample counter, mode latch and output register.
    // The output register is deliberately independent of start_i.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_ACCUM;
            r_count <= '0;
            r_mode  <= POOL_AVG;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            if (valid_o & ready_i) begin
                valid_o <= 1'b0;
            end
            if (w_load) begin
                data_o  <= w_results;
                valid_o <= 1'b1;
            end

            if (start_i) begin
                r_state <= ST_ACCUM;
                r_count <= '0;
            end else begin
                case (r_state)
                    ST_ACCUM: begin
                        if (w_accept) begin
                            if (w_first) begin
                                r_mode <= w_accMode;
                            end
                            if (r_count == LAST) begin
                                r_count <= '0;
                                r_state <= ST_FINISH;
                            end else begin
                                r_count <= r_count + CW'(1);
                            end
                        end
                    end
                    ST_FINISH: begin
                        if (w_load) begin
                            r_state <= ST_ACCUM;
                        end
                    end
                    default: r_state <= ST_ACCUM;
                endcase
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        pool_channel #(
            .WORD_SIZE  (WORD_SIZE),
            .INPUT_SIZE (INPUT_SIZE),
            .RECIP_BITS (RECIP_BITS)
        ) u_lane (
            .i_clk     (clk_i),
            .i_rst     (reset_i),
            .i_clear   (w_clear),
            .i_accept  (w_accept),
            .i_first   (w_first),
            .i_accMode (w_accMode),
            .i_resMode (r_mode),
            .i_data    (data_i[g*WORD_SIZE +: WORD_SIZE]),
            .o_result  (w_results[g*WORD_SIZE +: WORD_SIZE])
        );
    end

endmodule

// File: tb/tb_global_pool_layer.sv
// ---------------------------------------------------------------------------
// tb_global_pool_layer
// Directed and randomized frames on a 2-lane, 4-sample configuration of the
// pooling layer, compared against a plain-arithmetic reference of the pooling
// rules.
// ---------------------------------------------------------------------------
module tb_global_pool_layer;

    localparam int WS = 16;
    localparam int CH = 2;
    localparam int IN = 4;

    logic              clk_i   = 1'b0;
    logic              reset_i = 1'b1;
    logic              start_i = 1'b0;
    logic [1:0]        mode_i  = 2'd0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [CH*WS-1:0]  data_i  = '0;
    logic              valid_o;
    logic              ready_i = 1'b1;
    logic [CH*WS-1:0]  data_o;

    int passCount  = 0;
    int checkCount = 0;
    int frameBuf [CH][IN];

    global_pool_layer #(
        .WORD_SIZE  (WS),
        .INT_BITS   (4),
        .CHANNELS   (CH),
        .INPUT_SIZE (IN),
        .RECIP_BITS (16)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference pooling of one lane of frameBuf: mode 0 average, 1 max,
    // 2 average of saturated absolute values.
    function automatic logic [15:0] refLane(input int lane, input int mode);
        longint total;
        longint best;
        longint v;
        longint scaled;
        longint recip;
        recip = (65536 + IN / 2) / IN;
        total = 0;
        best  = -32768;
        for (int i = 0; i < IN; i++) begin
            v = frameBuf[lane][i];
            if (mode == 2) begin
                if (v < 0) v = -v;
                if (v > 32767) v = 32767;
            end
            total += v;
            if (v > best) best = v;
        end
        if (mode == 1) return 16'(best);
        scaled = (total * recip + 32768) >>> 16;
        if (scaled > 32767)  scaled = 32767;
        if (scaled < -32768) scaled = -32768;
        return 16'(scaled);
    endfunction

    function automatic logic [31:0] refFrame(input logic [1:0] firstMode);
        int m;
        m = (firstMode == 2'd1) ? 1 : (firstMode == 2'd2) ? 2 : 0;
        return {refLane(1, m), refLane(0, m)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        checkCount++;
    endtask

    // Presents one sample vector and returns #1 after the edge that took it.
    task automatic applyStimulus(input int l0, input int l1, input logic [1:0] mode);
        int guard;
        guard   = 0;
        valid_i = 1'b1;
        data_i  = {16'(l1), 16'(l0)};
        mode_i  = mode;
        while (!ready_o && guard < 20) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (guard == 20) checkOutput("ready_timeout", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic fillRandom();
        logic signed [15:0] r;
        for (int l = 0; l < CH; l++) begin
            for (int i = 0; i < IN; i++) begin
                r = 16'($urandom);
                if ($urandom_range(0, 7) == 0) r = 16'sh8000;
                frameBuf[l][i] = r;
            end
        end
    endtask

    task automatic fillConst(input int l0, input int l1);
        for (int i = 0; i < IN; i++) begin
            frameBuf[0][i] = l0;
            frameBuf[1][i] = l1;
        end
    endtask

    // Sends frameBuf (first two samples with firstMode, rest with laterMode),
    // checks FINISH after the last accept and the result one cycle later.
    task automatic runFrame(input string tag, input logic [1:0] firstMode,
                            input logic [1:0] laterMode, input logic [31:0] expData);
        for (int i = 0; i < IN; i++) begin
            applyStimulus(frameBuf[0][i], frameBuf[1][i], (i < 2) ? firstMode : laterMode);
        end
        checkOutput({tag, "_finish_ready"}, {31'd0, ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        checkOutput({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        checkOutput({tag, "_data"}, data_o, expData);
        checkOutput({tag, "_ready_back"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        logic [1:0]  fm;
        logic [1:0]  lm;
        logic [31:0] expA;
        logic [31:0] expB;

        // Reset state
        #2;
        checkOutput("reset_ready", {31'd0, ready_o}, 32'd1);
        checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("reset_data", data_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Average of 1,2,3,4 and of four -1.0 samples
        frameBuf[0] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
        fillConst(frameBuf[0][0], -4096);
        frameBuf[0] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
        runFrame("avg", 2'd0, 2'd0, 32'hF000_2800);

        // Max with negatives and most-negative lane
        frameBuf[0] = '{-5, 3, -1, 2};
        frameBuf[1] = '{-32768, -32768, -32768, -32768};
        runFrame("max", 2'd1, 2'd1, 32'h8000_0003);

        // Mode change mid-frame is ignored
        fillRandom();
        runFrame("max_midchange", 2'd1, 2'd0, refFrame(2'd1));

        // Abs-average with most-negative saturation
        fillConst(-32768, -4096);
        frameBuf[1] = '{-4096, 4096, -4096, 4096};
        runFrame("absavg", 2'd2, 2'd2, 32'h1000_7FFF);

        // Randomized frames and modes, including code 3
        for (int k = 0; k < 8; k++) begin
            fm = 2'($urandom_range(0, 3));
            lm = 2'($urandom_range(0, 3));
            fillRandom();
            runFrame($sformatf("rand%0d", k), fm, lm, refFrame(fm));
        end

        // Back-pressure: frame A held while frame B waits in FINISH
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        fillRandom();
        expA = refFrame(2'd0);
        runFrame("bp_a", 2'd0, 2'd0, expA);
        fillRandom();
        expB = refFrame(2'd1);
        for (int i = 0; i < IN; i++) applyStimulus(frameBuf[0][i], frameBuf[1][i], 2'd1);
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("bp_hold_ready", {31'd0, ready_o}, 32'd0);
        checkOutput("bp_hold_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("bp_hold_data", data_o, expA);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("bp_b_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("bp_b_data", data_o, expB);
        checkOutput("bp_b_ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        checkOutput("bp_drained", {31'd0, valid_o}, 32'd0);

        // start_i abort after two samples, with a sample offered alongside it
        fillRandom();
        applyStimulus(frameBuf[0][0], frameBuf[1][0], 2'd1);
        applyStimulus(frameBuf[0][1], frameBuf[1][1], 2'd1);
        valid_i = 1'b1;
        data_i  = 32'h7FFF_7FFF;
        mode_i  = 2'd1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        valid_i = 1'b0;
        checkOutput("start_ready", {31'd0, ready_o}, 32'd1);
        checkOutput("start_valid", {31'd0, valid_o}, 32'd0);
        fillConst(32'h2000, 32'h2000);
        runFrame("after_start", 2'd0, 2'd0, 32'h2000_2000);

        // Asynchronous reset while holding a result and mid-frame
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        fillRandom();
        runFrame("pre_reset", 2'd2, 2'd2, refFrame(2'd2));
        applyStimulus(1234, -1234, 2'd1);
        applyStimulus(-999, 999, 2'd1);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("areset_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("areset_data", data_o, 32'd0);
        checkOutput("areset_ready", {31'd0, ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        ready_i = 1'b1;
        fillRandom();
        runFrame("post_reset", 2'd2, 2'd2, refFrame(2'd2));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
